// File: rtl/game2048_pkg.sv
// rtl/game2048_pkg.sv - shared 2048 board types, direction codes, controller states and board predicates
package game2048_pkg;

  typedef logic [11:0] tile_t;
  typedef tile_t [3:0][3:0] board_t;  // [row][col], row 0 at the top, col 0 at the left
  typedef logic [19:0] score_t;

  localparam logic [3:0] DIR_UP    = 4'b0001;
  localparam logic [3:0] DIR_DOWN  = 4'b0010;
  localparam logic [3:0] DIR_LEFT  = 4'b0100;
  localparam logic [3:0] DIR_RIGHT = 4'b1000;

  localparam score_t SCORE_MAX = 20'hFFFFF;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_APPLY,
    ST_SPAWN,
    ST_CHECK,
    ST_DONE
  } ctrl_state_e;

  function automatic logic dir_is_one_hot(logic [3:0] d);
    return (d != 4'b0000) && ((d & (d - 4'b0001)) == 4'b0000);
  endfunction

  function automatic logic board_has_tile(board_t b, tile_t v);
    logic hit;
    hit = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (b[r][c] == v) hit = 1'b1;
    return hit;
  endfunction

  // A move exists while any cell is empty or two orthogonal neighbours can merge.
  function automatic logic board_can_move(board_t b);
    logic ok;
    ok = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (b[r][c] == 12'h000) ok = 1'b1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if ((b[r][c] != 12'h000) && (b[r][c] == b[r][c+1])) ok = 1'b1;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++)
        if ((b[r][c] != 12'h000) && (b[r][c] == b[r+1][c])) ok = 1'b1;
    return ok;
  endfunction

endpackage

// File: rtl/board_state_ctrl_if.sv
// rtl/board_state_ctrl_if.sv - request, preload and merge-path signals of board_state_ctrl
// master: drives dir_valid/dir_in/load_valid/load_board and the merge results
//         board_merged/score_update; observes board/direction/score/ready/game_won/game_over.
// slave:  the controller side (inverse directions).
interface board_state_ctrl_if;
  import game2048_pkg::*;

  logic       dir_valid;
  logic [3:0] dir_in;
  logic       load_valid;
  board_t     load_board;
  board_t     board_merged;
  score_t     score_update;
  board_t     board;
  logic [3:0] direction;
  score_t     score;
  logic       ready;
  logic       game_won;
  logic       game_over;

  modport master (
    output dir_valid, dir_in, load_valid, load_board, board_merged, score_update,
    input  board, direction, score, ready, game_won, game_over
  );

  modport slave (
    input  dir_valid, dir_in, load_valid, load_board, board_merged, score_update,
    output board, direction, score, ready, game_won, game_over
  );

endinterface

// File: rtl/spawn_lfsr.sv
// rtl/spawn_lfsr.sv - free-running 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) for tile spawning
// clk, rst_n: clock and async active-low reset (loads SEED)
// rand_val:   current LFSR state, advances every cycle out of reset
module spawn_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] rand_val
);

  logic [15:0] lfsr_q;

  // Right-shifting form: taps 16,14,13,11 land on bits 0,2,3,5.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  assign rand_val = lfsr_q;

endmodule

// File: rtl/board_state_ctrl.sv
// rtl/board_state_ctrl.sv - owner of the 2048 board: moves, score, tile spawn, win/game-over
// clk, rst_n: clock and async active-low reset
// bus (slave): dir_valid/dir_in move request, load_valid/load_board preload,
//              board_merged/score_update from the merge block, board/direction to it,
//              score, ready (IDLE only), sticky game_won and game_over.
module board_state_ctrl
  import game2048_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter tile_t       WIN_TILE  = 12'h800
) (
  input logic               clk,
  input logic               rst_n,
  board_state_ctrl_if.slave bus
);

  ctrl_state_e state_q, state_d;
  board_t      board_q, board_d;
  logic [3:0]  dir_q, dir_d;
  score_t      score_q, score_d;
  logic        won_q, won_d;
  logic        over_q, over_d;
  logic [3:0]  ptr_q, ptr_d;         // cell under examination: row = ptr[3:2], col = ptr[1:0]
  logic [1:0]  spawn_cnt_q, spawn_cnt_d;
  logic [3:0]  scan_cnt_q, scan_cnt_d;  // occupied cells passed for the current tile

  logic [15:0] rnd;
  logic        unused_rand_bits;
  logic [20:0] score_sum;
  tile_t       spawn_val;

  spawn_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .rand_val (rnd)
  );

  assign unused_rand_bits = ^rnd[15:8];
  assign score_sum        = {1'b0, score_q} + {1'b0, bus.score_update};
  // Mostly 2s, a 4 when the nibble happens to be zero.
  assign spawn_val        = (rnd[7:4] != 4'h0) ? 12'h002 : 12'h004;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      board_q     <= '0;
      dir_q       <= 4'b0000;
      score_q     <= '0;
      won_q       <= 1'b0;
      over_q      <= 1'b0;
      ptr_q       <= 4'h0;
      spawn_cnt_q <= 2'd2;
      scan_cnt_q  <= 4'h0;
    end else begin
      state_q     <= state_d;
      board_q     <= board_d;
      dir_q       <= dir_d;
      score_q     <= score_d;
      won_q       <= won_d;
      over_q      <= over_d;
      ptr_q       <= ptr_d;
      spawn_cnt_q <= spawn_cnt_d;
      scan_cnt_q  <= scan_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    board_d     = board_q;
    dir_d       = dir_q;
    score_d     = score_q;
    won_d       = won_q;
    over_d      = over_q;
    ptr_d       = ptr_q;
    spawn_cnt_d = spawn_cnt_q;
    scan_cnt_d  = scan_cnt_q;

    case (state_q)
      ST_INIT: begin
        ptr_d      = rnd[3:0];
        scan_cnt_d = 4'h0;
        state_d    = ST_SPAWN;
      end

      ST_IDLE: begin
        if (bus.load_valid) begin
          board_d = bus.load_board;
          state_d = ST_CHECK;
        end else if (bus.dir_valid && dir_is_one_hot(bus.dir_in)) begin
          dir_d   = bus.dir_in;
          state_d = ST_APPLY;
        end
      end

      // board_merged is a combinational function of board_q/dir_q this cycle.
      ST_APPLY: begin
        dir_d = 4'b0000;
        if (bus.board_merged != board_q) begin
          board_d     = bus.board_merged;
          score_d     = score_sum[20] ? SCORE_MAX : score_sum[19:0];
          spawn_cnt_d = 2'd1;
          ptr_d       = rnd[3:0];
          scan_cnt_d  = 4'h0;
          state_d     = ST_SPAWN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SPAWN: begin
        if (board_q[ptr_q[3:2]][ptr_q[1:0]] == 12'h000) begin
          board_d[ptr_q[3:2]][ptr_q[1:0]] = spawn_val;
          spawn_cnt_d = spawn_cnt_q - 2'd1;
          ptr_d       = rnd[3:0];
          scan_cnt_d  = 4'h0;
          if (spawn_cnt_q == 2'd1) state_d = ST_CHECK;
        end else begin
          ptr_d      = ptr_q + 4'h1;
          scan_cnt_d = scan_cnt_q + 4'h1;
          // Sixteenth occupied cell in a row: board is full, give up on this tile.
          if (scan_cnt_q == 4'hF) state_d = ST_CHECK;
        end
      end

      ST_CHECK: begin
        won_d = won_q | board_has_tile(board_q, WIN_TILE);
        if (!board_can_move(board_q)) begin
          over_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_DONE: state_d = ST_DONE;

      default: state_d = ST_INIT;
    endcase
  end

  assign bus.board     = board_q;
  assign bus.direction = dir_q;
  assign bus.score     = score_q;
  assign bus.ready     = (state_q == ST_IDLE);
  assign bus.game_won  = won_q;
  assign bus.game_over = over_q;

endmodule

// File: tb/tb_board_state_ctrl.sv
// tb/tb_board_state_ctrl.sv - randomized self-checking bench for board_state_ctrl with a 2048 reference model
module tb_board_state_ctrl
  import game2048_pkg::*;
;

  typedef struct packed {
    board_t b;
    score_t s;
  } mres_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  board_state_ctrl_if bus ();

  board_state_ctrl #(.LFSR_SEED(16'hACE1), .WIN_TILE(12'h800)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [15:0] lf [0:8191];

  board_t m_board;
  score_t m_score;
  logic   m_won, m_over;
  logic   exp_ready  = 1'b0;
  logic   exp_stable = 1'b0;
  logic   chk_en     = 1'b0;

  // 2048 slide-and-merge: each line compacted toward the move side, equal
  // neighbours merged once, score is the sum of the merged tiles.
  function automatic mres_t merge_model(board_t b, logic [3:0] d);
    mres_t r;
    tile_t line [4];
    tile_t comp [4];
    tile_t outl [4];
    int nt, o, i;
    r.b = b;
    r.s = '0;
    if (!(d == DIR_UP || d == DIR_DOWN || d == DIR_LEFT || d == DIR_RIGHT)) return r;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) begin
        case (d)
          DIR_UP:   line[j] = b[j][k];
          DIR_DOWN: line[j] = b[3-j][k];
          DIR_LEFT: line[j] = b[k][j];
          default:  line[j] = b[k][3-j];
        endcase
        outl[j] = '0;
        comp[j] = '0;
      end
      nt = 0;
      for (int j = 0; j < 4; j++)
        if (line[j] != 12'h000) begin
          comp[nt] = line[j];
          nt++;
        end
      i = 0;
      o = 0;
      while (i < nt) begin
        if (i + 1 < nt && comp[i] == comp[i+1]) begin
          outl[o] = comp[i] + comp[i];
          r.s = r.s + 20'(outl[o]);
          i += 2;
        end else begin
          outl[o] = comp[i];
          i++;
        end
        o++;
      end
      for (int j = 0; j < 4; j++)
        case (d)
          DIR_UP:   r.b[j][k]   = outl[j];
          DIR_DOWN: r.b[3-j][k] = outl[j];
          DIR_LEFT: r.b[k][j]   = outl[j];
          default:  r.b[k][3-j] = outl[j];
        endcase
    end
    return r;
  endfunction

  mres_t live;
  always_comb begin
    live             = merge_model(bus.board, bus.direction);
    bus.board_merged = live.b;
    bus.score_update = live.s;
  end

  // Play continues if some direction would change the board (or it has an empty cell).
  function automatic bit model_can_move(board_t b);
    logic [3:0] dirs [4];
    dirs[0] = DIR_UP; dirs[1] = DIR_DOWN; dirs[2] = DIR_LEFT; dirs[3] = DIR_RIGHT;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (b[r][c] == 12'h000) return 1'b1;
    for (int k = 0; k < 4; k++)
      if (merge_model(b, dirs[k]).b != b) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int count_tiles(board_t b);
    int n = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (b[r][c] != 12'h000) n++;
    return n;
  endfunction

  function automatic bit tiles_are_2_or_4(board_t b);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!(b[r][c] == 12'h000 || b[r][c] == 12'h002 || b[r][c] == 12'h004)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", 192'(bus.ready), 192'(exp_ready));
      if (exp_stable) begin
        chk("board", 192'(bus.board), 192'(m_board));
        chk("score", 192'(bus.score), 192'(m_score));
        chk("game_won", 192'(bus.game_won), 192'(m_won));
        chk("game_over", 192'(bus.game_over), 192'(m_over));
        chk("direction_idle", 192'(bus.direction), 192'(4'b0000));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Places cnt tiles; the pointer starts at p0 and the first examined cell sees lfsr step s0.
  task automatic model_spawn(input int cnt_in, input logic [3:0] p0, input int s0, output int ncyc);
    int cnt, s, scans;
    logic [3:0] p;
    logic [15:0] v;
    cnt = cnt_in; s = s0; scans = 0; p = p0; ncyc = 0;
    while (cnt > 0 && scans < 16) begin
      v = lf[s];
      ncyc++;
      s++;
      if (m_board[p[3:2]][p[1:0]] == 12'h000) begin
        m_board[p[3:2]][p[1:0]] = (v[7:4] != 4'h0) ? 12'h002 : 12'h004;
        cnt--;
        p = v[3:0];
        scans = 0;
      end else begin
        p = p + 4'h1;
        scans++;
      end
    end
  endtask

  task automatic model_check();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (m_board[r][c] == 12'h800) m_won = 1'b1;
    if (!model_can_move(m_board)) m_over = 1'b1;
  endtask

  task automatic finish_txn(input int busy);
    exp_ready  = 1'b0;
    exp_stable = 1'b0;
    repeat (busy) tick();
    exp_stable = 1'b1;
    exp_ready  = !m_over;
  endtask

  task automatic do_reset_init();
    int k;
    chk_en = 1'b0;
    rst_n = 1'b0;
    bus.dir_valid = 1'b0; bus.dir_in = 4'b0000;
    bus.load_valid = 1'b0; bus.load_board = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 192'(bus.ready), 192'(1'b0));
    chk("rst_board", 192'(bus.board), 192'(0));
    chk("rst_score", 192'(bus.score), 192'(0));
    chk("rst_flags", 192'({bus.game_won, bus.game_over}), 192'(2'b00));
    chk("rst_direction", 192'(bus.direction), 192'(4'b0000));
    rst_n = 1'b1;
    cyc = 0;
    m_board = '0; m_score = '0; m_won = 1'b0; m_over = 1'b0;
    model_spawn(2, lf[0][3:0], 1, k);
    model_check();
    exp_ready = 1'b0; exp_stable = 1'b0; chk_en = 1'b1;
    repeat (k + 2) tick();
    exp_ready = 1'b1; exp_stable = 1'b1;
  endtask

  task automatic do_move(input logic [3:0] d);
    mres_t r;
    int k, a, sum;
    bus.dir_valid = 1'b1; bus.dir_in = d;
    tick();
    bus.dir_valid = 1'b0; bus.dir_in = 4'b0000;
    a = cyc;
    if (m_over || $countones(d) != 1) return;
    r = merge_model(m_board, d);
    if (r.b == m_board) begin
      finish_txn(1);
      return;
    end
    m_board = r.b;
    sum = int'(m_score) + int'(r.s);
    m_score = (sum > 'hFFFFF) ? 20'hFFFFF : score_t'(sum);
    model_spawn(1, lf[a][3:0], a + 1, k);
    model_check();
    finish_txn(k + 2);
  endtask

  task automatic do_load(input board_t b, input bit with_dir);
    bus.load_valid = 1'b1; bus.load_board = b;
    bus.dir_valid = with_dir; bus.dir_in = DIR_LEFT;
    tick();
    bus.load_valid = 1'b0; bus.dir_valid = 1'b0; bus.dir_in = 4'b0000;
    if (m_over) return;
    m_board = b;
    model_check();
    finish_txn(1);
  endtask

  initial begin
    board_t b, snap;
    score_t s_snap;
    logic [3:0] d;
    logic [3:0] dirs [4];
    dirs[0] = DIR_UP; dirs[1] = DIR_DOWN; dirs[2] = DIR_LEFT; dirs[3] = DIR_RIGHT;

    lf[0] = 16'hACE1;
    for (int i = 1; i < 8192; i++)
      lf[i] = {^(lf[i-1] & 16'h002D), lf[i-1][15:1]};
    chk("lfsr_step1", 192'(lf[1]), 192'(16'h5670));

    // Power-up: two starting tiles.
    do_reset_init();
    chk("init_tile_count", 192'(count_tiles(bus.board)), 192'(2));
    chk("init_tile_values", 192'(tiles_are_2_or_4(bus.board)), 192'(1'b1));
    chk("init_score", 192'(bus.score), 192'(0));

    // Row merge to the left.
    b = '0;
    b[0][0] = 12'h002; b[0][1] = 12'h002; b[0][2] = 12'h004; b[0][3] = 12'h004;
    do_load(b, 1'b0);
    do_move(DIR_LEFT);
    chk("left_row0", 192'({bus.board[0][1], bus.board[0][0]}), 192'({12'h008, 12'h004}));
    chk("left_score", 192'(bus.score), 192'(20'h0000C));
    chk("left_tiles", 192'(count_tiles(bus.board)), 192'(3));

    // Column merge up, then a move that changes nothing.
    b = '0;
    b[0][0] = 12'h002; b[1][0] = 12'h002;
    do_load(b, 1'b0);
    do_move(DIR_UP);
    chk("up_cell00", 192'(bus.board[0][0]), 192'(12'h004));
    chk("up_score", 192'(bus.score), 192'(20'h00010));
    b = '0;
    b[0][0] = 12'h004; b[0][1] = 12'h002;
    do_load(b, 1'b0);
    do_move(DIR_UP);
    chk("noop_board", 192'(bus.board), 192'(b));
    chk("noop_score", 192'(bus.score), 192'(20'h00010));

    // Reaching the win tile keeps the game alive.
    b = '0;
    b[0][0] = 12'h400; b[0][1] = 12'h400;
    do_load(b, 1'b1);
    do_move(DIR_LEFT);
    chk("win_cell00", 192'(bus.board[0][0]), 192'(12'h800));
    chk("win_flag", 192'(bus.game_won), 192'(1'b1));
    chk("win_not_over", 192'(bus.game_over), 192'(1'b0));
    chk("win_score", 192'(bus.score), 192'(20'h00810));

    // Non-one-hot request is dropped.
    snap = bus.board; s_snap = bus.score;
    do_move(4'b0011);
    chk("bad_dir_board", 192'(bus.board), 192'(snap));
    chk("bad_dir_score", 192'(bus.score), 192'(s_snap));

    // Random play: preloads (sometimes full boards), invalid and valid moves.
    for (int it = 0; it < 160; it++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        bit full;
        full = ($urandom_range(0, 2) == 0);
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            if (!full && $urandom_range(0, 1) == 0) b[r][c] = 12'h000;
            else b[r][c] = tile_t'(12'h002 << $urandom_range(0, 4));
        do_load(b, bit'($urandom_range(0, 1)));
      end else if (sel == 1) begin
        d = 4'($urandom_range(0, 15));
        if ($countones(d) == 1) d = d | 4'b1001;
        do_move(d);
      end else begin
        do_move(dirs[$urandom_range(0, 3)]);
      end
      if (m_over) begin
        do_move(DIR_DOWN);
        do_reset_init();
      end
    end

    // Checkerboard has no move: game over, requests ignored afterwards.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        b[r][c] = ((r + c) % 2 == 1) ? 12'h004 : 12'h002;
    do_load(b, 1'b0);
    chk("over_flag", 192'(bus.game_over), 192'(1'b1));
    chk("over_ready", 192'(bus.ready), 192'(1'b0));
    do_move(DIR_LEFT);
    do_load('0, 1'b0);
    repeat (3) tick();
    chk("done_board", 192'(bus.board), 192'(b));

    // Reset in the middle of a spawn.
    do_reset_init();
    b = '0;
    b[3][3] = 12'h002;
    do_load(b, 1'b0);
    bus.dir_valid = 1'b1; bus.dir_in = DIR_LEFT;
    tick();
    bus.dir_valid = 1'b0; bus.dir_in = 4'b0000;
    exp_ready = 1'b0; exp_stable = 1'b0;
    tick();
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midspawn_board", 192'(bus.board), 192'(0));
    chk("midspawn_ready", 192'(bus.ready), 192'(1'b0));
    chk("midspawn_score", 192'(bus.score), 192'(0));
    chk("midspawn_dir", 192'(bus.direction), 192'(4'b0000));
    do_reset_init();
    repeat (2) tick();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
